clm_decode_serial: RTL and testbench

Bit-serial CLM decoder: accepts one masked codeword (state_t, 8+d bits) per transaction and recovers the unmasked byte by GF(2) row-dot-products with a decoding matrix, one output bit per clock. It is the inverse end of the encode path that builds codewords from the random mask r with the generator matrix. It sits at the output boundary of the masked datapath and trades latency for area: one AND-XOR row unit instead of eight in parallel.

---
 rtl/clm_decode_serial_pkg.sv | 16 +
 rtl/clm_decode_serial_if.sv | 20 ++
 rtl/clm_row_dot.sv | 10 +
 rtl/clm_decode_serial.sv | 62 ++++++
 tb/tb_clm_decode_serial.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/clm_decode_serial_pkg.sv
// clm_decode_serial_pkg: shared CLM decode types; CLM_DEC_MASK_OUT_EN adds mask-recovery rows.
package clm_decode_serial_pkg;
  localparam int d = 4;
  localparam int W = 8 + d;
  localparam int CW = $clog2(W + 1);
`ifdef CLM_DEC_MASK_OUT_EN
  localparam int N = W;
`else
  localparam int N = 8;
`endif
  typedef logic [W-1:0] state_t;
  typedef logic [d-1:0] red_poly_t;
  typedef logic [7:0] byte_t;
  typedef logic [7:0][W-1:0] dec_matrix_t;
  typedef logic [d-1:0][W-1:0] mr_matrix_t;
endpackage

// File: rtl/clm_decode_serial_if.sv
// clm_decode_serial_if: codeword in / byte out handshake bus; E and out_r exist only with CLM_DEC_MASK_OUT_EN.
interface clm_decode_serial_if;
  import clm_decode_serial_pkg::*;
  logic in_valid;
  logic in_ready;
  state_t in_state;
  dec_matrix_t D;
  logic out_valid;
  logic out_ready;
  byte_t out_byte;
`ifdef CLM_DEC_MASK_OUT_EN
  mr_matrix_t E;
  red_poly_t out_r;
  modport master(output in_valid, in_state, D, E, out_ready, input in_ready, out_valid, out_byte, out_r);
  modport slave(input in_valid, in_state, D, E, out_ready, output in_ready, out_valid, out_byte, out_r);
`else
  modport master(output in_valid, in_state, D, out_ready, input in_ready, out_valid, out_byte);
  modport slave(input in_valid, in_state, D, out_ready, output in_ready, out_valid, out_byte);
`endif
endinterface

// File: rtl/clm_row_dot.sv
// clm_row_dot: GF(2) dot product of a codeword with one matrix row.
module clm_row_dot
  import clm_decode_serial_pkg::*;
(
  input  state_t state,
  input  state_t row,
  output logic   dot
);
  assign dot = ^(state & row);
endmodule

// File: rtl/clm_decode_serial.sv
// clm_decode_serial: bit-serial CLM decoder, one row product per clock.
// CLM_DEC_MASK_OUT_EN appends d mask-recovery rows from E into out_r.
module clm_decode_serial
  import clm_decode_serial_pkg::*;
(
  input logic clk,
  input logic rst_n,
  clm_decode_serial_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t st;
  logic [CW-1:0] cnt;
  state_t state_reg;
  state_t row;
  logic dot;
  assign bus.in_ready = st == IDLE;
  // matrices are read live; only the row selected by cnt reaches the dot unit
  always_comb begin
    row = '0;
    for (int k = 0; k < 8; k++) if (cnt == CW'(k)) row = bus.D[k];
`ifdef CLM_DEC_MASK_OUT_EN
    for (int j = 0; j < d; j++) if (cnt == CW'(8 + j)) row = bus.E[j];
`endif
  end
  clm_row_dot u_dot (.state(state_reg), .row(row), .dot(dot));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      state_reg <= '0;
      bus.out_valid <= 1'b0;
      bus.out_byte <= '0;
`ifdef CLM_DEC_MASK_OUT_EN
      bus.out_r <= '0;
`endif
    end else begin
      case (st)
        IDLE: if (bus.in_valid) begin
          state_reg <= bus.in_state;
          cnt <= '0;
          st <= RUN;
        end
        RUN: begin
          for (int k = 0; k < 8; k++) if (cnt == CW'(k)) bus.out_byte[k] <= dot;
`ifdef CLM_DEC_MASK_OUT_EN
          for (int j = 0; j < d; j++) if (cnt == CW'(8 + j)) bus.out_r[j] <= dot;
`endif
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            st <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          st <= IDLE;
          bus.out_valid <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clm_decode_serial.sv
// tb_clm_decode_serial: randomized scoreboard bench for clm_decode_serial (either CLM_DEC_MASK_OUT_EN build).
module tb_clm_decode_serial;
  import clm_decode_serial_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  clm_decode_serial_if bus();
  clm_decode_serial dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {byte_t b; red_poly_t r;} exp_t;
  exp_t expq[$];
  int accq[$];
  int acc_log[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit busy = 0;
  exp_t cur;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // reference: each output bit is the parity of the codeword masked by its row
  function automatic exp_t model(state_t s);
    exp_t e;
    e = '0;
    for (int k = 0; k < 8; k++) e.b[k] = 1'($countones(s & bus.D[k]) % 2);
`ifdef CLM_DEC_MASK_OUT_EN
    for (int j = 0; j < d; j++) e.r[j] = 1'($countones(s & bus.E[j]) % 2);
`endif
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      accq.push_back(cyc);
      acc_log.push_back(cyc);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst_n || !bus.out_valid) busy = 0;
    else begin
      if (!busy) begin
        busy = 1;
        if (expq.size() == 0 || accq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no result");
          cur.b = bus.out_byte;
`ifdef CLM_DEC_MASK_OUT_EN
          cur.r = bus.out_r;
`endif
        end else begin
          cur = expq.pop_front();
          chk("latency", cyc - accq.pop_front() - 1, N);
        end
      end
      chk("out_byte", {24'd0, bus.out_byte}, {24'd0, cur.b});
`ifdef CLM_DEC_MASK_OUT_EN
      chk("out_r", 32'(bus.out_r), 32'(cur.r));
`endif
    end
  end

  task automatic set_identity();
    for (int k = 0; k < 8; k++) bus.D[k] = state_t'(1) << k;
`ifdef CLM_DEC_MASK_OUT_EN
    for (int j = 0; j < d; j++) bus.E[j] = state_t'(1) << (8 + j);
`endif
  endtask

  task automatic set_random();
    for (int k = 0; k < 8; k++) bus.D[k] = state_t'($urandom);
`ifdef CLM_DEC_MASK_OUT_EN
    for (int j = 0; j < d; j++) bus.E[j] = state_t'($urandom);
`endif
  endtask

  task automatic wait_acc(int n);
    int t;
    t = 0;
    while (acc_log.size() <= n && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (acc_log.size() <= n) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected one within 50 cycles");
    end
  endtask

  task automatic offer(state_t s);
    int n;
    n = acc_log.size();
    expq.push_back(model(s));
    bus.in_state = s;
    bus.in_valid = 1;
    wait_acc(n);
    bus.in_valid = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while (!(expq.size() == 0 && !bus.out_valid && bus.in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", expq.size());
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wait_valid", 32'(bus.out_valid), 1);
  endtask

  initial begin
    int n;
    state_t a, b;
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.in_state = '0;
    bus.D = '0;
`ifdef CLM_DEC_MASK_OUT_EN
    bus.E = '0;
`endif
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_byte", 32'(bus.out_byte), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    set_identity();
    offer(state_t'({4'b1011, 8'h5A}));
    drain();
    chk("pass_through", 32'(bus.out_byte), 32'h5A);
`ifdef CLM_DEC_MASK_OUT_EN
    chk("mask_out", 32'(bus.out_r), 32'hB);
`endif
    for (int k = 0; k < 8; k++) bus.D[k] = '1;
    offer(state_t'(12'b0000_0001_1111));
    drain();
    chk("parity5", 32'(bus.out_byte), 32'hFF);
    offer(state_t'(12'b1000_0001_1111));
    drain();
    chk("parity6", 32'(bus.out_byte), 32'h00);
    for (int i = 0; i < 20; i++) begin
      set_random();
      offer(state_t'($urandom));
      drain();
    end
    set_identity();
    bus.out_ready = 0;
    offer(state_t'(12'h3C7));
    wait_valid();
    b = state_t'(12'h9E1);
    expq.push_back(model(b));
    bus.in_state = b;
    bus.in_valid = 1;
    n = acc_log.size();
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_no_accept", acc_log.size(), n);
      chk("bp_out_byte", 32'(bus.out_byte), 32'hC7);
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("bp_release_idle", 32'(bus.in_ready), 1);
    chk("bp_release_valid", 32'(bus.out_valid), 0);
    chk("bp_release_noacc", acc_log.size(), n);
    @(negedge clk);
    chk("bp_accept_next", acc_log.size(), n + 1);
    bus.in_valid = 0;
    drain();
    set_random();
    a = state_t'($urandom);
    b = state_t'($urandom);
    n = acc_log.size();
    expq.push_back(model(a));
    bus.in_state = a;
    bus.in_valid = 1;
    wait_acc(n);
    expq.push_back(model(b));
    bus.in_state = b;
    wait_acc(n + 1);
    bus.in_valid = 0;
    if (acc_log.size() >= n + 2) chk("b2b_spacing", acc_log[n+1] - acc_log[n], N + 2);
    drain();
    set_identity();
    offer(state_t'(12'h0A5));
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrun_out_valid", 32'(bus.out_valid), 0);
    chk("midrun_out_byte", 32'(bus.out_byte), 0);
    chk("midrun_in_ready", 32'(bus.in_ready), 1);
    expq.delete();
    accq.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (20) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'(bus.out_valid), 0);
    end
    offer(state_t'(12'h6B4));
    drain();
    chk("post_reset_decode", 32'(bus.out_byte), 32'hB4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
